// File: rtl/bp_be_pkg.sv
// Shared definitions for the BE issue queue: pointer/lane-count widths and the
// lane slice macro used when indexing packed multi-lane buses.
`ifndef BP_BE_PKG_SV
`define BP_BE_PKG_SV
`define BP_BE_SLICE(lane, w) ((lane)*(w)) +: (w)

package bp_be_pkg;

   localparam int default_issue_width_gp = 2;

   typedef logic [$clog2(default_issue_width_gp+1)-1:0] lane_cnt_t;

   // One extra MSB acts as the wrap bit so full and empty are distinguishable.
   function automatic int ptr_width(input int els);
      return $clog2(els) + 1;
   endfunction

   function automatic int lane_cnt_width(input int issue_width);
      return $clog2(issue_width + 1);
   endfunction

endpackage
`endif

// File: rtl/bp_be_wrap_ptr.sv
// Registered wrap-bit pointer with variable increment and a load port that
// takes priority over the increment (used for roll and clear).
module bp_be_wrap_ptr
   import bp_be_pkg::*;
#(
   parameter int ptr_w_p = 4,
   parameter int inc_w_p = 2
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [inc_w_p-1:0] inc_i,
   input  logic               load_v_i,
   input  logic [ptr_w_p-1:0] load_val_i,
   output logic [ptr_w_p-1:0] ptr_o
);

   logic [ptr_w_p-1:0] ptr_r;

   always_ff @(posedge clk_i) begin
      if (reset_i)
         ptr_r <= '0;
      else if (load_v_i)
         ptr_r <= load_val_i;
      else
         ptr_r <= ptr_r + ptr_w_p'(inc_i);
   end

   assign ptr_o = ptr_r;

endmodule

// File: rtl/bp_be_issue_queue_nw.sv
// N-wide in-order issue buffer: speculative issue pointer with commit pointer
// so the scheduler can roll back to the last commit point.
module bp_be_issue_queue_nw
   import bp_be_pkg::*;
#(
   parameter int width_p       = 128,
   parameter int els_p         = 8,
   parameter int issue_width_p = 2
) (
   input  logic                                 clk_i,
   input  logic                                 reset_i,
   input  logic [issue_width_p-1:0]             enq_v_i,
   input  logic [issue_width_p*width_p-1:0]     enq_data_i,
   output logic                                 enq_ready_o,
   output logic [issue_width_p-1:0]             deq_v_o,
   output logic [issue_width_p*width_p-1:0]     deq_data_o,
   input  logic [$clog2(issue_width_p+1)-1:0]   deq_cnt_i,
   input  logic [$clog2(issue_width_p+1)-1:0]   commit_cnt_i,
   input  logic                                 roll_i,
   input  logic                                 clr_i,
   output logic                                 empty_o
);

   localparam int ptr_w_lp = ptr_width(els_p);
   localparam int idx_w_lp = ptr_w_lp - 1;
   localparam int cnt_w_lp = lane_cnt_width(issue_width_p);

   logic [ptr_w_lp-1:0] wptr, rptr, cptr;
   logic [ptr_w_lp-1:0] occupancy, unissued, rptr_load_val;
   logic [ptr_w_lp:0]   free_cnt;
   logic [cnt_w_lp-1:0] enq_n, wptr_inc, rptr_inc;
   logic                enq_fire, rptr_load_v;
   logic [idx_w_lp-1:0] widx [issue_width_p];
   logic [idx_w_lp-1:0] ridx [issue_width_p];
   logic [width_p-1:0]  mem  [els_p];

   assign occupancy = wptr - cptr;
   assign unissued  = wptr - rptr;
   assign free_cnt  = (ptr_w_lp+1)'(els_p) - {1'b0, occupancy};

   // All-or-nothing admission: space for a full-width enqueue is required.
   assign enq_ready_o = !reset_i && (free_cnt >= (ptr_w_lp+1)'(issue_width_p));
   assign enq_fire    = enq_ready_o && !clr_i;
   assign empty_o     = (wptr == rptr);

   always_comb begin
      enq_n = '0;
      for (int k = 0; k < issue_width_p; k++)
         enq_n = enq_n + cnt_w_lp'(enq_v_i[k]);
   end

   assign wptr_inc = enq_fire ? enq_n : '0;

   // Roll rewinds to the commit point including this cycle's commit.
   assign rptr_load_v   = clr_i || roll_i;
   assign rptr_load_val = clr_i ? '0 : cptr + ptr_w_lp'(commit_cnt_i);
   assign rptr_inc      = roll_i ? '0 : deq_cnt_i;

   bp_be_wrap_ptr #(.ptr_w_p(ptr_w_lp), .inc_w_p(cnt_w_lp)) u_wptr (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .inc_i      (wptr_inc),
      .load_v_i   (clr_i),
      .load_val_i ('0),
      .ptr_o      (wptr)
   );

   bp_be_wrap_ptr #(.ptr_w_p(ptr_w_lp), .inc_w_p(cnt_w_lp)) u_rptr (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .inc_i      (rptr_inc),
      .load_v_i   (rptr_load_v),
      .load_val_i (rptr_load_val),
      .ptr_o      (rptr)
   );

   bp_be_wrap_ptr #(.ptr_w_p(ptr_w_lp), .inc_w_p(cnt_w_lp)) u_cptr (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .inc_i      (commit_cnt_i),
      .load_v_i   (clr_i),
      .load_val_i ('0),
      .ptr_o      (cptr)
   );

   always_comb begin
      for (int k = 0; k < issue_width_p; k++) begin
         widx[k] = idx_w_lp'(wptr + ptr_w_lp'(k));
         ridx[k] = idx_w_lp'(rptr + ptr_w_lp'(k));
      end
   end

   // Storage is data-only and never reset.
   always_ff @(posedge clk_i) begin
      for (int k = 0; k < issue_width_p; k++)
         if (enq_fire && enq_v_i[k])
            mem[widx[k]] <= enq_data_i[`BP_BE_SLICE(k, width_p)];
   end

   always_comb begin
      deq_v_o    = '0;
      deq_data_o = '0;
      for (int k = 0; k < issue_width_p; k++) begin
         deq_v_o[k]                           = (unissued > ptr_w_lp'(k));
         deq_data_o[`BP_BE_SLICE(k, width_p)] = mem[ridx[k]];
      end
   end

endmodule

// File: doc/bp_be_issue_queue_nw.md
# bp_be_issue_queue_nw

Parametrised N-wide, in-order issue buffer between the FE queue interface and the BE scheduler. It accepts up to `issue_width_p` fetch packets per cycle and presents up to `issue_width_p` oldest unissued packets per cycle. It holds issued-but-uncommitted packets so the scheduler can roll back to the last commit point. It generalises the fixed two-lane `fe_queue1/2` pairing to arbitrary width and depth, and adds commit/roll semantics.

## Interface
Parameters:
- `width_p`, 128, bits per packet (`fe_queue_width_lp` at instantiation)
- `els_p`, 8, entries; power of two, ≥ 2*`issue_width_p`
- `issue_width_p`, 2, lanes per cycle for enqueue, dequeue and commit

Ports:
- `clk_i` in 1: single clock
- `reset_i` in 1: synchronous, active-high reset
- `enq_v_i` in `issue_width_p`: enqueue valids; must be thermometer (lane k set ⇒ lanes <k set)
- `enq_data_i` in `issue_width_p*width_p`: lane k in bits [k*width_p +: width_p]
- `enq_ready_o` out 1: all asserted lanes are accepted this cycle
- `deq_v_o` out `issue_width_p`: thermometer; lane k holds the (k+1)-th oldest unissued entry
- `deq_data_o` out `issue_width_p*width_p`: X when the lane is invalid
- `deq_cnt_i` in `$clog2(issue_width_p+1)`: lanes consumed this cycle; ≤ popcount(`deq_v_o`)
- `commit_cnt_i` in `$clog2(issue_width_p+1)`: oldest issued entries retired this cycle
- `roll_i` in 1: rewind issue pointer to commit point
- `clr_i` in 1: discard all contents
- `empty_o` out 1: no unissued entries

## Operation
- State: storage array `els_p`×`width_p` flops; pointers `wptr`, `rptr` (speculative issue) and `cptr` (commit). Each pointer is `$clog2(els_p)+1` bits, and the MSB is the wrap bit.
- Invariant: `cptr` ≤ `rptr` ≤ `wptr` in modular order.
- Occupancy is `wptr-cptr` and counts issued-uncommitted entries. Unissued count is `wptr-rptr`.
- `enq_ready_o` = !reset_i && (`els_p` − occupancy ≥ `issue_width_p`). This is a function of registered state only.
- Enqueue: if `enq_ready_o`, write lanes 0..n−1 to `wptr+k` (mod `els_p`), then `wptr += n`. Here n = popcount(`enq_v_i`).
- Dequeue: `deq_v_o[k]` = (unissued > k). `deq_data_o[k]` = mem[`rptr+k`], read combinationally from flops. Then `rptr += deq_cnt_i`.
- Commit: `cptr += commit_cnt_i`. Behaviour is undefined if `commit_cnt_i` > `rptr-cptr` (bench asserts this).
- Roll: `rptr_next = cptr_next`, where `cptr_next` includes this cycle's commit. `deq_cnt_i` is ignored that cycle. An enqueue in the same cycle still completes.
- Clear: all pointers go to 0. Enqueue, dequeue, commit and roll in the same cycle are discarded.
- Priority: `reset_i` > `clr_i` > `roll_i` > `deq_cnt_i`. Commit and enqueue are applied independently of roll.
- Pointer adds are modulo 2*`els_p`: natural overflow of the `+1`-bit pointer. The low bits index storage.
- `empty_o` = (`wptr`==`rptr`).

## Timing
- Reset: all pointers 0. `deq_v_o`=0, `empty_o`=1. `enq_ready_o`=0 while `reset_i` is high and 1 on the first cycle after.
- Enqueue-to-dequeue latency is 1 cycle; there is no same-cycle bypass.
- Commit frees space in 1 cycle: `enq_ready_o` reflects it the next cycle.
- After roll, `deq_v_o` shows the rewound entries the next cycle.
- Full boundary: with occupancy > `els_p`−`issue_width_p`, `enq_ready_o`=0 even for a single-lane enqueue. This is a conservative all-or-nothing rule.
- Wrap-around: lanes straddling index `els_p`−1→0 read and write correctly within one cycle.
- Reset or clear mid-stream: contents are lost, and storage is not zeroed.

## Structure
- Shared package `bp_be_pkg` holds:
  - the pointer-width localparam function
  - the lane-count typedef (`$clog2(issue_width_p+1)`)
  - the packet-slice macro used by lane indexing
- Sub-module `bp_be_wrap_ptr`: registered pointer with variable increment (0..`issue_width_p`), load-value input (for roll/clear) and synchronous reset. It is instantiated three times.
- Storage is a flop array with `issue_width_p` write ports and `issue_width_p` read ports, inline in the top.

## Test plan
- Reset, then enqueue 2 lanes A,B → the next cycle `deq_v_o`=2'b11 with lanes A,B; `empty_o`=0.
- `els_p`=8, W=2: enqueue 7 entries with no commit → `enq_ready_o`=0 at occupancy 7. Commit 1 → `enq_ready_o`=1 the next cycle.
- Issue 4 entries, commit 1, assert `roll_i` → the next cycle `deq_v_o` presents entry 2 on lane 0; occupancy stays 3.
- Drive pointers to `wptr`=7: a 2-lane enqueue writes slots 7 and 0. Dequeue returns both, in order, from slots 7 and 0.
- Assert `clr_i` together with a 2-lane enqueue and `roll_i` → the next cycle `empty_o`=1, `deq_v_o`=0, `enq_ready_o`=1.
- Assert `reset_i` for 1 cycle while occupancy is 5 → all outputs return to reset values; the first post-reset enqueue lands at slot 0.
